// File: rtl/caliptra_ss_bfm_rst_int_responder.sv
// ============================================================================
// caliptra_ss_bfm_rst_int_responder
//
// Purpose:
//   Testbench-side responder that sits between the tb services block and the
//   caliptra_ss DUT reset/interrupt pins.
//   - Turns level-style reset request flags into pwrgood / rst_b sequences.
//   - Answers every request with a 4-phase done handshake.
//   - Turns per-bit toggle requests into MCU external interrupt levels.
//
// Ports:
//   core_clk, rst                  clock and synchronous active-high reset
//   assert_hard_rst_flag           request: power-off reset
//   deassert_hard_rst_flag         request: power-on release
//   assert_rst_flag                request: warm reset assert
//   deassert_rst_flag              request: warm reset release
//   *_done                         done for the matching request (4-phase)
//   toggle_cptra_ss_mcu_ext_int    per-bit interrupt toggle requests
//   cptra_ss_mcu_ext_int_o         interrupt lines to the MCU
//   cptra_ss_pwrgood_o             SoC power-good
//   cptra_ss_rst_b_o               SoC reset, active-low
//   test_pass_i                    pass indication from the checker
//   end_test_success               sticky end-of-test success
//   busy_o                         reset sequence in progress
//   seq_err_o                      sticky illegal-sequence flag
//
// Configuration macro:
//   CALIPTRA_SS_BFM_INT_PULSE_EN   when defined, each toggle edge produces a
//                                  single-cycle interrupt pulse instead of
//                                  inverting the interrupt level.
// ============================================================================
module caliptra_ss_bfm_rst_int_responder #(
  parameter int EXT_INT_W           = 255,
  parameter int HARD_RST_ASSERT_CYC = 16,
  parameter int RST_ASSERT_CYC      = 8,
  parameter int PWRGOOD_SETTLE_CYC  = 4
) (
  input  logic                 core_clk,
  input  logic                 rst,
  input  logic                 assert_hard_rst_flag,
  input  logic                 deassert_hard_rst_flag,
  input  logic                 assert_rst_flag,
  input  logic                 deassert_rst_flag,
  output logic                 assert_hard_rst_flag_done,
  output logic                 deassert_hard_rst_flag_done,
  output logic                 assert_rst_flag_done,
  output logic                 deassert_rst_flag_done,
  input  logic [EXT_INT_W-1:0] toggle_cptra_ss_mcu_ext_int,
  output logic [EXT_INT_W-1:0] cptra_ss_mcu_ext_int_o,
  output logic                 cptra_ss_pwrgood_o,
  output logic                 cptra_ss_rst_b_o,
  input  logic                 test_pass_i,
  output logic                 end_test_success,
  output logic                 busy_o,
  output logic                 seq_err_o
);

  localparam int MAX_AB  = (HARD_RST_ASSERT_CYC > RST_ASSERT_CYC) ? HARD_RST_ASSERT_CYC : RST_ASSERT_CYC;
  localparam int MAX_CYC = (MAX_AB > PWRGOOD_SETTLE_CYC) ? MAX_AB : PWRGOOD_SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The counter is loaded with N-1 on entry and the state is left on the
  // cycle it reads 0, so each hold state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] HARD_LOAD   = CNT_W'(HARD_RST_ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] WARM_LOAD   = CNT_W'(RST_ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(PWRGOOD_SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    HARD_HOLD,
    PG_SETTLE,
    WARM_HOLD,
    DONE
  } state_e;

  // Request index, also the bit position in the request vectors.
  typedef enum logic [1:0] {
    REQ_AH = 2'd0,
    REQ_DH = 2'd1,
    REQ_AR = 2'd2,
    REQ_DR = 2'd3
  } req_e;

  state_e           state_q, state_d;
  req_e             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwrgood_q, pwrgood_d;
  logic             rst_b_q, rst_b_d;
  logic             seq_err_q, seq_err_d;
  logic             ets_q;

  logic [3:0] req_flag;
  logic [3:0] req_q;
  logic [3:0] req_edge;
  logic [3:0] pending_q;
  logic [3:0] req_any;
  logic [3:0] start_clr;

  logic [EXT_INT_W-1:0] tog_q;
  logic [EXT_INT_W-1:0] tog_edge;
  logic [EXT_INT_W-1:0] ext_q;

  assign req_flag = {deassert_rst_flag, assert_rst_flag,
                     deassert_hard_rst_flag, assert_hard_rst_flag};
  assign req_edge = req_flag & ~req_q;
  // An edge seen this cycle can start a sequence without waiting a cycle
  // to land in the pending register first.
  assign req_any  = pending_q | req_edge;
  assign tog_edge = toggle_cptra_ss_mcu_ext_int & ~tog_q;

  // Next-state logic for the reset sequencer.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    pwrgood_d = pwrgood_q;
    rst_b_d   = rst_b_q;
    seq_err_d = seq_err_q;
    start_clr = '0;

    unique case (state_q)
      IDLE: begin
        if (req_any[REQ_AH]) begin
          state_d   = HARD_HOLD;
          active_d  = REQ_AH;
          cnt_d     = HARD_LOAD;
          pwrgood_d = 1'b0;
          rst_b_d   = 1'b0;
          start_clr = 4'b0001;
        end else if (req_any[REQ_DH]) begin
          state_d   = PG_SETTLE;
          active_d  = REQ_DH;
          cnt_d     = SETTLE_LOAD;
          pwrgood_d = 1'b1;
          start_clr = 4'b0010;
        end else if (req_any[REQ_AR]) begin
          state_d   = WARM_HOLD;
          active_d  = REQ_AR;
          cnt_d     = WARM_LOAD;
          rst_b_d   = 1'b0;
          start_clr = 4'b0100;
        end else if (req_any[REQ_DR]) begin
          // Releasing warm reset without power is illegal: rst_b stays low
          // but the request is still answered so the caller never stalls.
          state_d   = DONE;
          active_d  = REQ_DR;
          start_clr = 4'b1000;
          if (pwrgood_q) begin
            rst_b_d = 1'b1;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end

      HARD_HOLD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      PG_SETTLE, WARM_HOLD: begin
        // A fresh power-off request aborts a settle or warm hold; the
        // aborted request never sees its done.
        if (req_edge[REQ_AH]) begin
          state_d   = HARD_HOLD;
          active_d  = REQ_AH;
          cnt_d     = HARD_LOAD;
          pwrgood_d = 1'b0;
          rst_b_d   = 1'b0;
          seq_err_d = 1'b1;
          start_clr = 4'b0001;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          if (state_q == PG_SETTLE) begin
            rst_b_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (!req_flag[active_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, request edge detection and pending bookkeeping.
  // During reset the previous-value registers track the inputs so a flag
  // held high across reset release is not mistaken for a new request.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      active_q  <= REQ_AH;
      cnt_q     <= '0;
      pwrgood_q <= 1'b0;
      rst_b_q   <= 1'b0;
      seq_err_q <= 1'b0;
      ets_q     <= 1'b0;
      req_q     <= req_flag;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      pwrgood_q <= pwrgood_d;
      rst_b_q   <= rst_b_d;
      seq_err_q <= seq_err_d;
      req_q     <= req_flag;
      pending_q <= (pending_q | req_edge) & ~start_clr;
      if (test_pass_i && (state_q == IDLE) && pwrgood_q) begin
        ets_q <= 1'b1;
      end
    end
  end

  // Interrupt lines run independently of the reset sequencer.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      tog_q <= toggle_cptra_ss_mcu_ext_int;
      ext_q <= '0;
    end else begin
      tog_q <= toggle_cptra_ss_mcu_ext_int;
`ifdef CALIPTRA_SS_BFM_INT_PULSE_EN
      ext_q <= tog_edge;
`else
      ext_q <= ext_q ^ tog_edge;
`endif
    end
  end

  // Done decode: only the request that owns the DONE state is answered.
  always_comb begin
    assert_hard_rst_flag_done   = 1'b0;
    deassert_hard_rst_flag_done = 1'b0;
    assert_rst_flag_done        = 1'b0;
    deassert_rst_flag_done      = 1'b0;
    if (state_q == DONE) begin
      unique case (active_q)
        REQ_AH:  assert_hard_rst_flag_done   = 1'b1;
        REQ_DH:  deassert_hard_rst_flag_done = 1'b1;
        REQ_AR:  assert_rst_flag_done        = 1'b1;
        REQ_DR:  deassert_rst_flag_done      = 1'b1;
        default: assert_hard_rst_flag_done   = 1'b0;
      endcase
    end
  end

  assign cptra_ss_pwrgood_o     = pwrgood_q;
  assign cptra_ss_rst_b_o       = rst_b_q;
  assign seq_err_o              = seq_err_q;
  assign end_test_success       = ets_q;
  assign busy_o                 = (state_q != IDLE);
  assign cptra_ss_mcu_ext_int_o = ext_q;

endmodule

// File: tb/tb_caliptra_ss_bfm_rst_int_responder.sv
// Self-checking bench for caliptra_ss_bfm_rst_int_responder.
// Interrupt behaviour is checked from a vector table and from random toggles
// against a bit-vector model; reset sequencing is checked with hand-written
// sequences whose cycle counts come from the parameter values.
module tb_caliptra_ss_bfm_rst_int_responder;

  localparam int EXT_INT_W           = 255;
  localparam int HARD_RST_ASSERT_CYC = 16;
  localparam int RST_ASSERT_CYC      = 8;
  localparam int PWRGOOD_SETTLE_CYC  = 4;

  logic                 core_clk = 1'b0;
  logic                 rst;
  logic                 ah, dh, ar, dr;
  logic                 ah_done, dh_done, ar_done, dr_done;
  logic [EXT_INT_W-1:0] toggle;
  logic [EXT_INT_W-1:0] ext_int;
  logic                 pwrgood, rst_b;
  logic                 test_pass;
  logic                 ets, busy, seq_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic seq_done = 1'b0;

  always #5 core_clk = ~core_clk;

  caliptra_ss_bfm_rst_int_responder #(
    .EXT_INT_W          (EXT_INT_W),
    .HARD_RST_ASSERT_CYC(HARD_RST_ASSERT_CYC),
    .RST_ASSERT_CYC     (RST_ASSERT_CYC),
    .PWRGOOD_SETTLE_CYC (PWRGOOD_SETTLE_CYC)
  ) dut (
    .core_clk                   (core_clk),
    .rst                        (rst),
    .assert_hard_rst_flag       (ah),
    .deassert_hard_rst_flag     (dh),
    .assert_rst_flag            (ar),
    .deassert_rst_flag          (dr),
    .assert_hard_rst_flag_done  (ah_done),
    .deassert_hard_rst_flag_done(dh_done),
    .assert_rst_flag_done       (ar_done),
    .deassert_rst_flag_done     (dr_done),
    .toggle_cptra_ss_mcu_ext_int(toggle),
    .cptra_ss_mcu_ext_int_o     (ext_int),
    .cptra_ss_pwrgood_o         (pwrgood),
    .cptra_ss_rst_b_o           (rst_b),
    .test_pass_i                (test_pass),
    .end_test_success           (ets),
    .busy_o                     (busy),
    .seq_err_o                  (seq_err)
  );

  typedef struct {
    string                name;
    logic [EXT_INT_W-1:0] tog;
    logic [EXT_INT_W-1:0] exp;
  } int_vec_t;

  int_vec_t tbl [8];

  typedef enum int {S_AH_DONE, S_DH_DONE, S_AR_DONE, S_DR_DONE, S_RSTB} sel_e;

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one table row of toggle requests and let it be sampled.
  task automatic applyStimulus(input int_vec_t row);
    toggle = row.tog;
    tick();
  endtask

  function automatic logic peek(input sel_e s);
    case (s)
      S_AH_DONE: return ah_done;
      S_DH_DONE: return dh_done;
      S_AR_DONE: return ar_done;
      S_DR_DONE: return dr_done;
      default:   return rst_b;
    endcase
  endfunction

  // Bounded wait; n returns the ticks taken (max_cyc on timeout).
  task automatic waitFor(input sel_e s, input logic val, input int max_cyc, output int n);
    n = 0;
    while (peek(s) !== val && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pwrgood"}, pwrgood, 0);
    checkOutput({tag, "_rst_b"}, rst_b, 0);
    checkOutput({tag, "_dones"}, {ah_done, dh_done, ar_done, dr_done}, 0);
    checkOutput({tag, "_ext_int"}, ext_int, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_seq_err"}, seq_err, 0);
    checkOutput({tag, "_ets"}, ets, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [EXT_INT_W-1:0] b0, b1, b7, b200, b254, ones;
    int n;
    logic saw_ar;

    b0 = 1; b1 = b0 << 1; b7 = b0 << 7; b200 = b0 << 200; b254 = b0 << 254;
    ones = '1;

    // Toggle rows and the interrupt level expected right after each is sampled.
    tbl[0] = '{"int_b0_b200_rise",  b0 | b200,            0};
    tbl[1] = '{"int_b0_b200_fall",  0,                    0};
    tbl[2] = '{"int_b0_b200_rise2", b0 | b200,            0};
    tbl[3] = '{"int_b0_b200_fall2", 0,                    0};
    tbl[4] = '{"int_b1_b254_rise",  b1 | b254,            0};
    tbl[5] = '{"int_b7_added",      b1 | b254 | b7,       0};
    tbl[6] = '{"int_all_rise",      ones,                 0};
    tbl[7] = '{"int_all_fall",      0,                    0};
`ifdef CALIPTRA_SS_BFM_INT_PULSE_EN
    tbl[0].exp = b0 | b200;  tbl[1].exp = 0;
    tbl[2].exp = b0 | b200;  tbl[3].exp = 0;
    tbl[4].exp = b1 | b254;  tbl[5].exp = b7;
    tbl[6].exp = ~(b1 | b254 | b7); tbl[7].exp = 0;
`else
    tbl[0].exp = b0 | b200;  tbl[1].exp = b0 | b200;
    tbl[2].exp = 0;          tbl[3].exp = 0;
    tbl[4].exp = b1 | b254;  tbl[5].exp = b1 | b254 | b7;
    tbl[6].exp = ones;       tbl[7].exp = ones;
`endif

    rst = 1'b1; ah = 0; dh = 0; ar = 0; dr = 0; toggle = '0; test_pass = 0;
    repeat (3) tick();
    checkResetValues("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i].name, ext_int, tbl[i].exp);
    end

    fork
      begin : reset_sequences
        // Power-off reset with a 4-phase done.
        ah = 1; tick();
        checkOutput("ah_busy", busy, 1);
        checkOutput("ah_pwrgood_low", pwrgood, 0);
        checkOutput("ah_rst_b_low", rst_b, 0);
        waitFor(S_AH_DONE, 1, 40, n);
        checkOutput("ah_done_latency", n, HARD_RST_ASSERT_CYC);
        repeat (3) tick();
        checkOutput("ah_done_held", ah_done, 1);
        ah = 0; tick();
        checkOutput("ah_done_drop", ah_done, 0);
        checkOutput("ah_idle", busy, 0);

        // Power-on release: pwrgood first, rst_b after the settle time.
        dh = 1; tick();
        checkOutput("dh_pwrgood_high", pwrgood, 1);
        checkOutput("dh_rst_b_still_low", rst_b, 0);
        waitFor(S_RSTB, 1, 40, n);
        checkOutput("dh_settle_cycles", n, PWRGOOD_SETTLE_CYC);
        waitFor(S_DH_DONE, 1, 5, n);
        checkOutput("dh_done", dh_done, 1);
        dh = 0; tick();
        checkOutput("dh_done_drop", dh_done, 0);

        // end_test_success: sticky once pass seen while idle and powered.
        checkOutput("ets_before", ets, 0);
        test_pass = 1; tick();
        checkOutput("ets_set", ets, 1);
        test_pass = 0; tick();
        checkOutput("ets_sticky", ets, 1);

        // Simultaneous warm assert and power-on release: release runs first.
        ar = 1; dh = 1; tick();
        checkOutput("prio_busy", busy, 1);
        waitFor(S_DH_DONE, 1, 40, n);
        checkOutput("prio_dh_done_first", dh_done, 1);
        checkOutput("prio_ar_not_yet", ar_done, 0);
        checkOutput("prio_rst_b_high", rst_b, 1);
        dh = 0;
        waitFor(S_RSTB, 0, 10, n);
        checkOutput("prio_ar_rst_b_low", rst_b, 0);
        waitFor(S_AR_DONE, 1, 40, n);
        checkOutput("prio_ar_hold_cycles", n, RST_ASSERT_CYC);
        checkOutput("prio_ar_pwrgood_kept", pwrgood, 1);
        ar = 0; tick();
        checkOutput("prio_ar_done_drop", ar_done, 0);

        // Warm release with power present.
        dr = 1; tick();
        checkOutput("dr_rst_b_high", rst_b, 1);
        checkOutput("dr_done", dr_done, 1);
        checkOutput("dr_no_err", seq_err, 0);
        dr = 0; tick();
        checkOutput("dr_done_drop", dr_done, 0);

        // Power-off request aborts a warm hold three cycles in.
        ar = 1; tick();
        tick(); tick();
        ah = 1; tick();
        checkOutput("preempt_seq_err", seq_err, 1);
        checkOutput("preempt_pwrgood_low", pwrgood, 0);
        checkOutput("preempt_busy", busy, 1);
        n = 0; saw_ar = 0;
        while (!ah_done && n < 40) begin
          tick(); n++;
          if (ar_done) saw_ar = 1;
        end
        checkOutput("preempt_hard_cycles", n, HARD_RST_ASSERT_CYC);
        checkOutput("preempt_ar_done_never", saw_ar, 0);
        ah = 0; ar = 0; tick();
        checkOutput("preempt_idle", busy, 0);
        checkOutput("preempt_ar_done_after", ar_done, 0);
        seq_done = 1;
      end

      begin : random_interrupts
        logic [EXT_INT_W-1:0] prev_tog, new_tog, rises, exp_int;
        logic [255:0] r;
        int cyc;
        prev_tog = tbl[7].tog;
        exp_int  = tbl[7].exp;
        cyc = 0;
        while (!seq_done && cyc < 2000) begin
          for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom & $urandom;
          new_tog = r[EXT_INT_W-1:0];
          toggle  = new_tog;
          rises   = new_tog & ~prev_tog;
`ifdef CALIPTRA_SS_BFM_INT_PULSE_EN
          exp_int = rises;
`else
          exp_int = exp_int ^ rises;
`endif
          prev_tog = new_tog;
          tick();
          cyc++;
          checkOutput("rand_ext_int", ext_int, exp_int);
        end
        toggle = '0;
      end
    join

    // Reset after activity returns everything to reset values.
    rst = 1; tick(); tick();
    checkResetValues("rst_again");
    rst = 0; tick();

    // Warm release without power: error, rst_b held, done still returned.
    dr = 1; tick();
    checkOutput("dr_nopwr_rst_b", rst_b, 0);
    checkOutput("dr_nopwr_done", dr_done, 1);
    checkOutput("dr_nopwr_seq_err", seq_err, 1);
    dr = 0; tick();
    checkOutput("dr_nopwr_done_drop", dr_done, 0);

    // Reset mid-sequence discards the running and pending requests.
    ah = 1; tick();
    checkOutput("midrst_busy", busy, 1);
    ar = 1; tick();
    rst = 1; ah = 0; ar = 0; tick(); tick();
    rst = 0; repeat (3) tick();
    checkOutput("midrst_idle", busy, 0);
    checkOutput("midrst_seq_err_clr", seq_err, 0);
    checkOutput("midrst_rst_b", rst_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
